// File: rtl/pe_cluster.sv
// rtl/pe_cluster.sv - row-stationary 2-D convolution PE cluster with tag-matched multicast loading
module pe_cluster #(
    parameter int numPeX        = 14,
    parameter int numPeY        = 3,
    parameter int interfaceSize = 64,
    parameter int dataSize      = 8,
    parameter int wSpadNReg     = 16,
    parameter int aSpadNReg     = 16,
    parameter int rfNumRegister = 16,
    parameter int idSize        = 8,
    parameter int addrSize      = 16
) (
    input  logic                                  clk,
    input  logic                                  nrst,
    input  logic                                  cluster_enable_i,
    input  logic [idSize-1:0]                     act_id_scan_i,
    input  logic                                  act_id_wren_i,
    input  logic [idSize-1:0]                     weight_id_scan_i,
    input  logic                                  weight_id_wren_i,
    input  logic [idSize-1:0]                     act_mcn_tag_target_y,
    input  logic [idSize-1:0]                     act_mcn_tag_target_x,
    input  logic [idSize-1:0]                     weight_mcn_tag_target_y,
    input  logic [idSize-1:0]                     weight_mcn_tag_target_x,
    input  logic [dataSize-1:0]                   a_data_i,
    input  logic [dataSize-1:0]                   w_data_i,
    input  logic [7:0]                            ctrl_acount,
    input  logic [7:0]                            ctrl_wcount,
    input  logic                                  start_compute_i,
    output logic [numPeX*(2*dataSize+4)-1:0]      outs_write_data_o,
    output logic [addrSize-1:0]                   outs_write_addr_o,
    output logic                                  outs_valid,
    output logic                                  flag_done
);

    localparam int MAC_RES     = 2*dataSize + 4;
    localparam int NUM_REG_MCN = numPeY*numPeX + numPeY;
    localparam int W_IDX       = $clog2(wSpadNReg);
    localparam int A_IDX       = $clog2(aSpadNReg);
    localparam int WPTR_W      = W_IDX + 1;
    localparam int APTR_W      = A_IDX + 1;
    localparam logic [WPTR_W-1:0] W_PTR_LIM = WPTR_W'(wSpadNReg);
    localparam logic [APTR_W-1:0] A_PTR_LIM = APTR_W'(aSpadNReg);
    localparam logic [8:0]        W_RD_LIM  = 9'(wSpadNReg);
    localparam logic [8:0]        A_RD_LIM  = 9'(aSpadNReg);
    // Bus width and psum RF depth are carried for the surrounding system only
    localparam int RESERVED    = interfaceSize + rfNumRegister;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_DONE} state_t;

    logic [31:0]                w_unused_reserved;
    logic [idSize-1:0]          r_act_chain [NUM_REG_MCN];
    logic [idSize-1:0]          r_w_chain   [NUM_REG_MCN];
    logic [idSize-1:0]          r_act_id    [NUM_REG_MCN];
    logic [idSize-1:0]          r_w_id      [NUM_REG_MCN];
    logic signed [dataSize-1:0] r_wspad [numPeY][numPeX][wSpadNReg];
    logic signed [dataSize-1:0] r_aspad [numPeY][numPeX][aSpadNReg];
    logic [WPTR_W-1:0]          r_wptr  [numPeY][numPeX];
    logic [APTR_W-1:0]          r_aptr  [numPeY][numPeX];
    logic signed [MAC_RES-1:0]  r_acc   [numPeY][numPeX];
    logic                       w_act_hit [numPeY][numPeX];
    logic                       w_w_hit   [numPeY][numPeX];
    logic signed [dataSize-1:0] w_wval    [numPeY][numPeX];
    logic signed [dataSize-1:0] w_aval    [numPeY][numPeX];
    logic signed [2*dataSize-1:0] w_prod  [numPeY][numPeX];
    logic [MAC_RES-1:0]         w_col_sum [numPeX];
    logic                       w_act_tag_ok;
    logic                       w_w_tag_ok;
    logic [8:0]                 w_k_ext;
    logic [8:0]                 w_ja;
    state_t                     r_state;
    state_t                     w_next_state;
    logic [7:0]                 r_k;
    logic [7:0]                 r_j;
    logic                       w_k_last;
    logic                       w_counts_ok;
    logic                       w_j_more;
    logic                       w_enter_done;
    logic [numPeX*MAC_RES-1:0]  r_outs_data;
    logic [addrSize-1:0]        r_outs_addr;
    logic                       r_outs_valid;

    assign w_unused_reserved = 32'(RESERVED);

    assign outs_write_data_o = r_outs_data;
    assign outs_write_addr_o = r_outs_addr;
    assign outs_valid        = r_outs_valid;
    assign flag_done         = (r_state == S_DONE);

    // Shift both ID scan chains (oldest value ends up at entry 0) and commit them on write enable
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_REG_MCN; i++) begin
                r_act_chain[i] <= '0;
                r_w_chain[i]   <= '0;
                r_act_id[i]    <= '0;
                r_w_id[i]      <= '0;
            end
        end else if (cluster_enable_i) begin
            for (int i = 0; i < NUM_REG_MCN-1; i++) begin
                r_act_chain[i] <= r_act_chain[i+1];
                r_w_chain[i]   <= r_w_chain[i+1];
            end
            r_act_chain[NUM_REG_MCN-1] <= act_id_scan_i;
            r_w_chain[NUM_REG_MCN-1]   <= weight_id_scan_i;
            if (act_id_wren_i) begin
                for (int i = 0; i < NUM_REG_MCN; i++) r_act_id[i] <= r_act_chain[i];
            end
            if (weight_id_wren_i) begin
                for (int i = 0; i < NUM_REG_MCN; i++) r_w_id[i] <= r_w_chain[i];
            end
        end
    end

    // Tag match per PE: row tag against the row ID, column tag against that PE's column ID
    always_comb begin
        w_act_tag_ok = (act_mcn_tag_target_y != '1) && (act_mcn_tag_target_x != '1);
        w_w_tag_ok   = (weight_mcn_tag_target_y != '1) && (weight_mcn_tag_target_x != '1);
        for (int y = 0; y < numPeY; y++) begin
            for (int x = 0; x < numPeX; x++) begin
                w_act_hit[y][x] = w_act_tag_ok
                    && (act_mcn_tag_target_y == r_act_id[y])
                    && (act_mcn_tag_target_x == r_act_id[numPeY + y*numPeX + x]);
                w_w_hit[y][x] = w_w_tag_ok
                    && (weight_mcn_tag_target_y == r_w_id[y])
                    && (weight_mcn_tag_target_x == r_w_id[numPeY + y*numPeX + x]);
            end
        end
    end

    // Scratchpad loading; pointers saturate at the depth so overflow writes are dropped
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int y = 0; y < numPeY; y++) begin
                for (int x = 0; x < numPeX; x++) begin
                    r_wptr[y][x] <= '0;
                    r_aptr[y][x] <= '0;
                    for (int i = 0; i < wSpadNReg; i++) r_wspad[y][x][i] <= '0;
                    for (int i = 0; i < aSpadNReg; i++) r_aspad[y][x][i] <= '0;
                end
            end
        end else if (cluster_enable_i) begin
            for (int y = 0; y < numPeY; y++) begin
                for (int x = 0; x < numPeX; x++) begin
                    if (w_enter_done) begin
                        r_wptr[y][x] <= '0;
                        r_aptr[y][x] <= '0;
                    end else begin
                        if (w_w_hit[y][x] && (r_wptr[y][x] < W_PTR_LIM)) begin
                            r_wspad[y][x][r_wptr[y][x][W_IDX-1:0]] <= w_data_i;
                            r_wptr[y][x] <= r_wptr[y][x] + 1'b1;
                        end
                        if (w_act_hit[y][x] && (r_aptr[y][x] < A_PTR_LIM)) begin
                            r_aspad[y][x][r_aptr[y][x][A_IDX-1:0]] <= a_data_i;
                            r_aptr[y][x] <= r_aptr[y][x] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Operand fetch w[k], a[j+k] (zero beyond the spad) and the signed product per PE
    always_comb begin
        w_k_ext = {1'b0, r_k};
        w_ja    = {1'b0, r_j} + {1'b0, r_k};
        for (int y = 0; y < numPeY; y++) begin
            for (int x = 0; x < numPeX; x++) begin
                w_wval[y][x] = (w_k_ext < W_RD_LIM) ? r_wspad[y][x][r_k[W_IDX-1:0]] : '0;
                w_aval[y][x] = (w_ja < A_RD_LIM) ? r_aspad[y][x][w_ja[A_IDX-1:0]] : '0;
                w_prod[y][x] = w_wval[y][x] * w_aval[y][x];
            end
        end
    end

    // Vertical partial-sum reduction: column x collects output row x
    always_comb begin
        for (int x = 0; x < numPeX; x++) begin
            w_col_sum[x] = '0;
            for (int y = 0; y < numPeY; y++) begin
                w_col_sum[x] = w_col_sum[x] + r_acc[y][x];
            end
        end
    end

    // Next-state logic for the IDLE/MAC/OUT/DONE sequencer
    always_comb begin
        w_k_last     = (r_k == (ctrl_wcount - 8'd1));
        w_counts_ok  = (ctrl_wcount != 8'd0) && (ctrl_wcount <= ctrl_acount);
        w_j_more     = (({1'b0, r_j} + 9'd1) <= ({1'b0, ctrl_acount} - {1'b0, ctrl_wcount}));
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start_compute_i) w_next_state = w_counts_ok ? S_MAC : S_DONE;
            end
            S_MAC: begin
                if (w_k_last) w_next_state = S_OUT;
            end
            S_OUT: begin
                w_next_state = w_j_more ? S_MAC : S_DONE;
            end
            default: w_next_state = S_IDLE;
        endcase
        w_enter_done = (r_state != S_DONE) && (w_next_state == S_DONE);
    end

    // State register; a low enable freezes the sequencer
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else if (cluster_enable_i) begin
            r_state <= w_next_state;
        end
    end

    // Counters, accumulators and the registered output beat
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_k          <= '0;
            r_j          <= '0;
            r_outs_valid <= 1'b0;
            r_outs_data  <= '0;
            r_outs_addr  <= '0;
            for (int y = 0; y < numPeY; y++) begin
                for (int x = 0; x < numPeX; x++) r_acc[y][x] <= '0;
            end
        end else if (!cluster_enable_i) begin
            r_outs_valid <= 1'b0;
        end else begin
            r_outs_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_compute_i) begin
                        r_k <= '0;
                        r_j <= '0;
                        for (int y = 0; y < numPeY; y++) begin
                            for (int x = 0; x < numPeX; x++) r_acc[y][x] <= '0;
                        end
                    end
                end
                S_MAC: begin
                    for (int y = 0; y < numPeY; y++) begin
                        for (int x = 0; x < numPeX; x++) begin
                            r_acc[y][x] <= r_acc[y][x]
                                + {{(MAC_RES-2*dataSize){w_prod[y][x][2*dataSize-1]}}, w_prod[y][x]};
                        end
                    end
                    r_k <= w_k_last ? 8'd0 : (r_k + 8'd1);
                end
                S_OUT: begin
                    r_outs_valid <= 1'b1;
                    r_outs_addr  <= addrSize'(r_j);
                    for (int x = 0; x < numPeX; x++) begin
                        r_outs_data[x*MAC_RES +: MAC_RES] <= w_col_sum[x];
                    end
                    for (int y = 0; y < numPeY; y++) begin
                        for (int x = 0; x < numPeX; x++) r_acc[y][x] <= '0;
                    end
                    r_j <= r_j + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_cluster.sv
// tb/tb_pe_cluster.sv - self-checking bench for pe_cluster against a 2-D correlation model
module tb_pe_cluster;

    logic         clk = 1'b0;
    logic         nrst;
    logic         cluster_enable_i;
    logic [7:0]   act_id_scan_i;
    logic         act_id_wren_i;
    logic [7:0]   weight_id_scan_i;
    logic         weight_id_wren_i;
    logic [7:0]   act_mcn_tag_target_y;
    logic [7:0]   act_mcn_tag_target_x;
    logic [7:0]   weight_mcn_tag_target_y;
    logic [7:0]   weight_mcn_tag_target_x;
    logic [7:0]   a_data_i;
    logic [7:0]   w_data_i;
    logic [7:0]   ctrl_acount;
    logic [7:0]   ctrl_wcount;
    logic         start_compute_i;
    logic [279:0] outs_write_data_o;
    logic [15:0]  outs_write_addr_o;
    logic         outs_valid;
    logic         flag_done;

    int           n_pass = 0;
    int           n_fail = 0;
    int           n_total = 0;
    int           W [3][16];
    int           A [16][16];
    logic [19:0]  first_slice;

    pe_cluster dut (
        .clk                     (clk),
        .nrst                    (nrst),
        .cluster_enable_i        (cluster_enable_i),
        .act_id_scan_i           (act_id_scan_i),
        .act_id_wren_i           (act_id_wren_i),
        .weight_id_scan_i        (weight_id_scan_i),
        .weight_id_wren_i        (weight_id_wren_i),
        .act_mcn_tag_target_y    (act_mcn_tag_target_y),
        .act_mcn_tag_target_x    (act_mcn_tag_target_x),
        .weight_mcn_tag_target_y (weight_mcn_tag_target_y),
        .weight_mcn_tag_target_x (weight_mcn_tag_target_x),
        .a_data_i                (a_data_i),
        .w_data_i                (w_data_i),
        .ctrl_acount             (ctrl_acount),
        .ctrl_wcount             (ctrl_wcount),
        .start_compute_i         (start_compute_i),
        .outs_write_data_o       (outs_write_data_o),
        .outs_write_addr_o       (outs_write_addr_o),
        .outs_valid              (outs_valid),
        .flag_done               (flag_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [279:0] obs, input logic [279:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output row x, column j of the valid 2-D correlation of the 16x16 image with the 3xwc kernel
    function automatic logic [279:0] model_beat(input int j, input int wc);
        logic [279:0] v;
        int s;
        v = '0;
        for (int x = 0; x < 14; x++) begin
            s = 0;
            for (int y = 0; y < 3; y++) begin
                for (int k = 0; k < wc; k++) begin
                    if (j + k < 16) s += W[y][k] * A[x+y][j+k];
                end
            end
            v[x*20 +: 20] = s[19:0];
        end
        return v;
    endfunction

    task automatic fill_random();
        logic signed [7:0] b;
        for (int y = 0; y < 3; y++)
            for (int k = 0; k < 16; k++) begin b = 8'($urandom); W[y][k] = b; end
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin b = 8'($urandom); A[r][c] = b; end
    endtask

    // Weight row y is multicast to every PE in row y; activation row r goes to PEs with x+y == r
    task automatic load_all(input int ac, input int wc);
        for (int y = 0; y < 3; y++) begin
            for (int k = 0; k < wc; k++) begin
                weight_mcn_tag_target_y = 8'(y);
                weight_mcn_tag_target_x = 8'd0;
                w_data_i = 8'(W[y][k]);
                step();
            end
        end
        weight_mcn_tag_target_y = 8'hFF;
        weight_mcn_tag_target_x = 8'hFF;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < ac; c++) begin
                for (int y = 0; y < 3; y++) begin
                    act_mcn_tag_target_y = 8'(y);
                    act_mcn_tag_target_x = 8'(r);
                    a_data_i = 8'(A[r][c]);
                    step();
                end
            end
        end
        act_mcn_tag_target_y = 8'hFF;
        act_mcn_tag_target_x = 8'hFF;
    endtask

    task automatic run_check(input int ac, input int wc, input int drop_at, input string tag);
        int cycles;
        int nbeats;
        int n_out;
        int lat;
        n_out = (wc == 0 || wc > ac) ? 0 : ac - wc + 1;
        lat   = n_out * (wc + 1) + ((drop_at >= 0) ? 5 : 0);
        ctrl_acount = 8'(ac);
        ctrl_wcount = 8'(wc);
        start_compute_i = 1'b1;
        step();
        start_compute_i = 1'b0;
        cycles = 0;
        nbeats = 0;
        while (flag_done !== 1'b1 && cycles < 2000) begin
            step();
            cycles++;
            if (outs_valid === 1'b1) begin
                if (nbeats == 0) first_slice = outs_write_data_o[19:0];
                check({tag, "_addr"}, 280'(outs_write_addr_o), 280'(nbeats));
                check({tag, "_data"}, outs_write_data_o, model_beat(nbeats, wc));
                nbeats++;
            end
            if (drop_at >= 0 && cycles == drop_at) cluster_enable_i = 1'b0;
            if (drop_at >= 0 && cycles == drop_at + 5) cluster_enable_i = 1'b1;
        end
        check({tag, "_done"}, 280'(flag_done), 280'(1));
        check({tag, "_beats"}, 280'(nbeats), 280'(n_out));
        check({tag, "_latency"}, 280'(cycles), 280'(lat));
    endtask

    initial begin
        int wc;
        int ac;
        nrst = 1'b0;
        cluster_enable_i = 1'b1;
        act_id_scan_i = '0;
        act_id_wren_i = 1'b0;
        weight_id_scan_i = '0;
        weight_id_wren_i = 1'b0;
        act_mcn_tag_target_y = 8'hFF;
        act_mcn_tag_target_x = 8'hFF;
        weight_mcn_tag_target_y = 8'hFF;
        weight_mcn_tag_target_x = 8'hFF;
        a_data_i = '0;
        w_data_i = '0;
        ctrl_acount = '0;
        ctrl_wcount = '0;
        start_compute_i = 1'b0;
        first_slice = '0;
        repeat (3) step();
        check("rst_valid", 280'(outs_valid), 280'(0));
        check("rst_done", 280'(flag_done), 280'(0));
        check("rst_data", outs_write_data_o, 280'(0));
        check("rst_addr", 280'(outs_write_addr_o), 280'(0));
        nrst = 1'b1;
        step();

        // Act IDs: rows 0,1,2 and colID(y,x) = y+x; weight IDs: rows 0,1,2 and all colIDs 0
        for (int e = 0; e < 45; e++) begin
            act_id_scan_i    = (e < 3) ? 8'(e) : 8'((e - 3) / 14 + (e - 3) % 14);
            weight_id_scan_i = (e < 3) ? 8'(e) : 8'd0;
            step();
        end
        act_id_wren_i = 1'b1;
        weight_id_wren_i = 1'b1;
        step();
        act_id_wren_i = 1'b0;
        weight_id_wren_i = 1'b0;

        for (int y = 0; y < 3; y++) for (int k = 0; k < 16; k++) W[y][k] = 1;
        for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) A[r][c] = 1;
        load_all(16, 3);
        run_check(16, 3, -1, "ones");
        check("ones_o00", 280'(first_slice), 280'(9));

        run_check(4, 5, -1, "w_gt_a");
        run_check(16, 0, -1, "w_zero");

        for (int y = 0; y < 3; y++) for (int k = 0; k < 16; k++) W[y][k] = 3*y + k + 1;
        for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) A[r][c] = r + c;
        load_all(16, 3);
        run_check(16, 3, -1, "ramp");
        check("ramp_o00", 280'(first_slice), 280'(114));

        for (int y = 0; y < 3; y++) for (int k = 0; k < 16; k++) W[y][k] = -128;
        for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) A[r][c] = -128;
        load_all(16, 3);
        run_check(16, 3, -1, "neg");
        check("neg_o00", 280'(first_slice), 280'(147456));

        fill_random();
        wc = $urandom_range(3, 8);
        ac = $urandom_range(wc, 16);
        load_all(ac, wc);
        run_check(ac, wc, 2, "rand_freeze");

        fill_random();
        wc = $urandom_range(1, 16);
        ac = $urandom_range(wc, 16);
        load_all(ac, wc);
        run_check(ac, wc, -1, "rand");

        fill_random();
        load_all(16, 16);
        run_check(16, 16, -1, "full_kernel");

        // Reset in the middle of a run over stale spad contents, then restart without reloading
        ctrl_acount = 8'd16;
        ctrl_wcount = 8'd3;
        start_compute_i = 1'b1;
        step();
        start_compute_i = 1'b0;
        repeat (4) step();
        nrst = 1'b0;
        #1;
        check("midrst_valid", 280'(outs_valid), 280'(0));
        check("midrst_done", 280'(flag_done), 280'(0));
        check("midrst_data", outs_write_data_o, 280'(0));
        step();
        nrst = 1'b1;
        step();
        for (int y = 0; y < 3; y++) for (int k = 0; k < 16; k++) W[y][k] = 0;
        for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) A[r][c] = 0;
        run_check(16, 3, -1, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
